// File: rtl/upsampler_h_0_sequencer.sv
// upsampler_h_0_sequencer: zero-insertion and 3-tap window builder feeding the fp16 horizontal 2x upsampler convolution
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-low reset
//   pix_i        input sample, pix_valid_i / pix_ready_o handshake
//   window_o     3-tap window to the convolution, index 0 = left
//   kernel_o     constant [0.5, 1, 0.5] kernel
//   col_o/row_o  output column (0..2N-1) and row of window_o
//   valid_o      window_o/col_o/row_o valid
//   frame_end_o  pulse with the last window of the last row
module upsampler_h_0_sequencer #(
  parameter int FP_WIDTH   = 16,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [FP_WIDTH-1:0]          pix_i,
  input  logic                         pix_valid_i,
  output logic                         pix_ready_o,
  output logic [2:0][FP_WIDTH-1:0]     window_o,
  output logic [2:0][FP_WIDTH-1:0]     kernel_o,
  output logic [15:0]                  col_o,
  output logic [15:0]                  row_o,
  output logic                         valid_o,
  output logic                         frame_end_o
);
  typedef enum logic [1:0] {S_FIRST, S_ODD, S_EVEN, S_TAIL} state_t;
  localparam logic [15:0] K_LAST   = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] R_LAST   = 16'(IMG_HEIGHT - 1);
  localparam logic [15:0] COL_TAIL = 16'(2 * IMG_WIDTH - 1);
  localparam logic [FP_WIDTH-1:0] ZERO = '0;
  state_t state;
  logic [FP_WIDTH-1:0] p;
  logic [15:0] k;
  logic [15:0] r;
  assign kernel_o[0] = FP_WIDTH'(16'h3800);
  assign kernel_o[1] = FP_WIDTH'(16'h3C00);
  assign kernel_o[2] = FP_WIDTH'(16'h3800);
  // gated with rst_i so ready drops the instant reset asserts
  assign pix_ready_o = rst_i & (state == S_FIRST || state == S_ODD);
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= S_FIRST;
      p           <= '0;
      k           <= '0;
      r           <= '0;
      window_o    <= '0;
      col_o       <= '0;
      row_o       <= '0;
      valid_o     <= 1'b0;
      frame_end_o <= 1'b0;
    end else begin
      valid_o     <= 1'b0;
      frame_end_o <= 1'b0;
      case (state)
        S_FIRST: if (pix_valid_i) begin
          window_o[0] <= ZERO;
          window_o[1] <= pix_i;
          window_o[2] <= ZERO;
          col_o       <= '0;
          row_o       <= r;
          valid_o     <= 1'b1;
          p           <= pix_i;
          k           <= '0;
          state       <= (IMG_WIDTH == 1) ? S_TAIL : S_ODD;
        end
        S_ODD: if (pix_valid_i) begin
          window_o[0] <= p;
          window_o[1] <= ZERO;
          window_o[2] <= pix_i;
          col_o       <= (k << 1) | 16'd1;
          row_o       <= r;
          valid_o     <= 1'b1;
          p           <= pix_i;
          k           <= k + 16'd1;
          state       <= S_EVEN;
        end
        S_EVEN: begin
          window_o[0] <= ZERO;
          window_o[1] <= p;
          window_o[2] <= ZERO;
          col_o       <= k << 1;
          row_o       <= r;
          valid_o     <= 1'b1;
          state       <= (k == K_LAST) ? S_TAIL : S_ODD;
        end
        S_TAIL: begin
          // right edge replicates the last sample
          window_o[0] <= p;
          window_o[1] <= ZERO;
          window_o[2] <= p;
          col_o       <= COL_TAIL;
          row_o       <= r;
          valid_o     <= 1'b1;
          frame_end_o <= (r == R_LAST);
          r           <= (r == R_LAST) ? '0 : r + 16'd1;
          state       <= S_FIRST;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_upsampler_h_0_sequencer.sv
// tb_upsampler_h_0_sequencer: directed self-checking bench for upsampler_h_0_sequencer
module tb_upsampler_h_0_sequencer;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic [15:0] pix_i = '0;
  logic pix_valid_i = 1'b0;
  logic pix_ready_o;
  logic [2:0][15:0] window_o, kernel_o;
  logic [15:0] col_o, row_o;
  logic valid_o, frame_end_o;
  logic [15:0] pix1_i = '0;
  logic pix1_valid_i = 1'b0;
  logic pix1_ready_o;
  logic [2:0][15:0] window1_o, kernel1_o;
  logic [15:0] col1_o, row1_o;
  logic valid1_o, frame_end1_o;
  int tests = 0;
  int fails = 0;
  logic [15:0] px [4] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
  logic [15:0] el [8] = '{16'h0, 16'h3C00, 16'h0, 16'h4000, 16'h0, 16'h4200, 16'h0, 16'h4400};
  logic [15:0] ec [8] = '{16'h3C00, 16'h0, 16'h4000, 16'h0, 16'h4200, 16'h0, 16'h4400, 16'h0};
  logic [15:0] er [8] = '{16'h0, 16'h4000, 16'h0, 16'h4200, 16'h0, 16'h4400, 16'h0, 16'h4400};
  logic [2:0][15:0] kexp = {16'h3800, 16'h3C00, 16'h3800};

  upsampler_h_0_sequencer #(.FP_WIDTH(16), .IMG_WIDTH(4), .IMG_HEIGHT(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pix_i(pix_i), .pix_valid_i(pix_valid_i),
    .pix_ready_o(pix_ready_o), .window_o(window_o), .kernel_o(kernel_o),
    .col_o(col_o), .row_o(row_o), .valid_o(valid_o), .frame_end_o(frame_end_o));

  upsampler_h_0_sequencer #(.FP_WIDTH(16), .IMG_WIDTH(1), .IMG_HEIGHT(2)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .pix_i(pix1_i), .pix_valid_i(pix1_valid_i),
    .pix_ready_o(pix1_ready_o), .window_o(window1_o), .kernel_o(kernel1_o),
    .col_o(col1_o), .row_o(row1_o), .valid_o(valid1_o), .frame_end_o(frame_end1_o));

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    pix_valid_i = 1'b0;
    repeat (3) step();
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    tests++; if (frame_end_o !== 1'b0) begin fails++; $display("FAIL reset_frame_end got=%b exp=0", frame_end_o); end
    tests++; if (pix_ready_o !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b exp=0", pix_ready_o); end
    tests++; if (col_o !== 16'd0 || row_o !== 16'd0) begin fails++; $display("FAIL reset_colrow got=%0d/%0d exp=0/0", col_o, row_o); end
    tests++; if (window_o !== '0) begin fails++; $display("FAIL reset_window got=%h exp=0", window_o); end
    rst_i = 1'b1;
    #1;
    tests++; if (pix_ready_o !== 1'b1) begin fails++; $display("FAIL release_ready got=%b exp=1", pix_ready_o); end
  endtask

  task automatic test_idle();
    pix_valid_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL idle_valid cyc=%0d got=%b exp=0", i, valid_o); end
      tests++; if (pix_ready_o !== 1'b1) begin fails++; $display("FAIL idle_ready cyc=%0d got=%b exp=1", i, pix_ready_o); end
      tests++; if (kernel_o !== kexp) begin fails++; $display("FAIL idle_kernel got=%h exp=%h", kernel_o, kexp); end
    end
  endtask

  task automatic test_n1();
    logic [2:0][15:0] w0, w1;
    w0 = {16'h0, 16'h4500, 16'h0};
    w1 = {16'h4500, 16'h0, 16'h4500};
    for (int rw = 0; rw < 2; rw++) begin
      tests++; if (pix1_ready_o !== 1'b1) begin fails++; $display("FAIL n1_ready_first row=%0d got=%b exp=1", rw, pix1_ready_o); end
      pix1_i = 16'h4500;
      pix1_valid_i = 1'b1;
      step();
      pix1_valid_i = 1'b0;
      tests++; if (valid1_o !== 1'b1 || col1_o !== 16'd0 || row1_o !== 16'(rw)) begin fails++; $display("FAIL n1_col0 got=v%b c%0d r%0d exp=v1 c0 r%0d", valid1_o, col1_o, row1_o, rw); end
      tests++; if (window1_o !== w0) begin fails++; $display("FAIL n1_win0 got=%h exp=%h", window1_o, w0); end
      tests++; if (pix1_ready_o !== 1'b0) begin fails++; $display("FAIL n1_ready_tail got=%b exp=0", pix1_ready_o); end
      step();
      tests++; if (valid1_o !== 1'b1 || col1_o !== 16'd1 || row1_o !== 16'(rw)) begin fails++; $display("FAIL n1_col1 got=v%b c%0d r%0d exp=v1 c1 r%0d", valid1_o, col1_o, row1_o, rw); end
      tests++; if (window1_o !== w1) begin fails++; $display("FAIL n1_win1 got=%h exp=%h", window1_o, w1); end
      tests++; if (frame_end1_o !== (rw == 1)) begin fails++; $display("FAIL n1_frame_end got=%b exp=%b", frame_end1_o, rw == 1); end
      step();
      tests++; if (valid1_o !== 1'b0) begin fails++; $display("FAIL n1_gap_valid got=%b exp=0", valid1_o); end
    end
  endtask

  // Feeds one N=4 row from S_FIRST; stall inserts source-idle cycles before x_2.
  task automatic run_row(input int rw, input int stall, input bit fe, input int ncols);
    int idx, col, bubbles, cyc;
    bit acc, rdy_exp;
    logic [2:0][15:0] wexp;
    idx = 0; col = 0; bubbles = 0; cyc = 0;
    while (col < ncols && cyc < 40) begin
      pix_valid_i = !(col == 3 && bubbles < stall);
      pix_i = (idx < 4) ? px[idx] : 16'h0;
      rdy_exp = (col == 0) || (col % 2 == 1 && col < 7);
      tests++; if (pix_ready_o !== rdy_exp) begin fails++; $display("FAIL row_ready col=%0d got=%b exp=%b", col, pix_ready_o, rdy_exp); end
      acc = pix_valid_i & pix_ready_o;
      step();
      cyc++;
      if (acc) idx++;
      if (!pix_valid_i) begin
        bubbles++;
        tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL bubble_valid n=%0d got=%b exp=0", bubbles, valid_o); end
      end else begin
        wexp[0] = el[col]; wexp[1] = ec[col]; wexp[2] = er[col];
        tests++; if (valid_o !== 1'b1) begin fails++; $display("FAIL row_valid col=%0d got=%b exp=1", col, valid_o); end
        tests++; if (col_o !== 16'(col) || row_o !== 16'(rw)) begin fails++; $display("FAIL row_colrow got=%0d/%0d exp=%0d/%0d", col_o, row_o, col, rw); end
        tests++; if (window_o !== wexp) begin fails++; $display("FAIL row_window col=%0d got=%h exp=%h", col, window_o, wexp); end
        tests++; if (frame_end_o !== (fe && col == 7)) begin fails++; $display("FAIL row_frame_end col=%0d got=%b exp=%b", col, frame_end_o, fe && col == 7); end
        col++;
      end
    end
    tests++; if (col != ncols || bubbles != stall) begin fails++; $display("FAIL row_progress cols=%0d bubbles=%0d exp=%0d/%0d", col, bubbles, ncols, stall); end
  endtask

  task automatic test_row_data();
    run_row(0, 0, 1'b0, 8);
  endtask

  task automatic test_frame_wrap();
    run_row(1, 0, 1'b1, 8);
    run_row(0, 0, 1'b0, 8);
  endtask

  task automatic test_backpressure();
    run_row(1, 3, 1'b1, 8);
  endtask

  task automatic test_mid_row_reset();
    run_row(0, 0, 1'b0, 4);
    rst_i = 1'b0;
    #1;
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL midreset_valid got=%b exp=0", valid_o); end
    tests++; if (pix_ready_o !== 1'b0) begin fails++; $display("FAIL midreset_ready got=%b exp=0", pix_ready_o); end
    tests++; if (col_o !== 16'd0 || window_o !== '0) begin fails++; $display("FAIL midreset_outs got=%0d/%h exp=0/0", col_o, window_o); end
    pix_valid_i = 1'b0;
    step();
    rst_i = 1'b1;
    #1;
    run_row(0, 0, 1'b0, 8);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_n1();
    test_row_data();
    test_frame_wrap();
    test_backpressure();
    test_mid_row_reset();
    tests++; if (kernel_o !== kexp) begin fails++; $display("FAIL final_kernel got=%h exp=%h", kernel_o, kexp); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
